// File: rtl/pipe_hazard_ctrl.sv
// Hazard and stall controller for the 5-stage RV64 pipeline.
// Arbitrates halt, ebreak, mem-wait, redirect and load-use; keeps perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic                   id_rs1_used,
    input  logic                   id_rs2_used,
    input  logic [4:0]             id_rs1_addr,
    input  logic [4:0]             id_rs2_addr,
    input  logic                   ex_valid,
    input  logic                   ex_reg_wen,
    input  logic [4:0]             ex_reg_waddr,
    input  logic                   ex_is_load,
    input  logic                   ex_redirect,
    input  logic                   ex_ebreak,
    input  logic                   mem_dreq,
    input  logic                   mem_dready,
    output logic                   pc_hold,
    output logic                   if_id_hold,
    output logic                   if_id_flush,
    output logic                   id_ex_hold,
    output logic                   id_ex_bubble,
    output logic                   ex_mem_hold,
    output logic                   mem_wb_bubble,
    output logic                   halted,
    output logic                   timeout_err,
    output logic [STALL_CNT_W-1:0] stall_cnt,
    output logic [15:0]            flush_cnt
);

    localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MEM_TIMEOUT);

    typedef enum logic [1:0] {
        S_RUN,
        S_FLUSH,
        S_MEM_WAIT,
        S_HALT
    } state_t;

    state_t                 state_q, state_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [STALL_CNT_W-1:0] stall_q, stall_d;
    logic [15:0]            flush_q, flush_d;
    logic                   halted_q, halted_d;
    logic                   tmo_q, tmo_d;

    logic ev_load_use;
    logic ev_mem_wait;
    logic ev_redirect;
    logic ev_ebreak;

    logic frz;
    logic lu;
    logic rd;
    logic fl;
    logic eval_run;

    // Raw hazard events seen this cycle
    always_comb begin
        ev_load_use = ex_valid & ex_is_load & ex_reg_wen
                    & (ex_reg_waddr != 5'd0) & id_valid
                    & ((id_rs1_used & (id_rs1_addr == ex_reg_waddr))
                     | (id_rs2_used & (id_rs2_addr == ex_reg_waddr)));
        ev_mem_wait = mem_dreq & ~mem_dready;
        ev_redirect = ex_valid & ex_redirect;
        ev_ebreak   = ex_valid & ex_ebreak;
    end

    // Priority arbitration: next state, wait counter, flags and action flags
    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        halted_d = halted_q;
        tmo_d    = tmo_q;
        frz      = 1'b0;
        lu       = 1'b0;
        rd       = 1'b0;
        fl       = 1'b0;
        eval_run = 1'b0;

        case (state_q)
            S_HALT: begin
                frz = 1'b1;
            end
            S_MEM_WAIT: begin
                if (ev_ebreak || mem_dready) begin
                    eval_run = 1'b1;
                end else begin
                    frz    = 1'b1;
                    wait_d = wait_q + 1'b1;
                    if (wait_d >= WAIT_MAX) begin
                        state_d  = S_HALT;
                        halted_d = 1'b1;
                        tmo_d    = 1'b1;
                    end
                end
            end
            default: begin
                eval_run = 1'b1;
            end
        endcase

        if (eval_run) begin
            state_d = S_RUN;
            wait_d  = '0;
            if (ev_ebreak) begin
                frz      = 1'b1;
                state_d  = S_HALT;
                halted_d = 1'b1;
            end else if (ev_mem_wait) begin
                frz    = 1'b1;
                wait_d = WAIT_W'(1);
                if (MEM_TIMEOUT <= 1) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    tmo_d    = 1'b1;
                end else begin
                    state_d = S_MEM_WAIT;
                end
            end else if (ev_redirect) begin
                rd      = 1'b1;
                state_d = S_FLUSH;
            end else if (ev_load_use) begin
                lu = 1'b1;
            end
            // stale fetch squash, dropped when the pipe freezes instead
            fl = (state_q == S_FLUSH) & ~frz;
        end
    end

    // Pipeline register controls, forced to a safe pattern during reset
    always_comb begin
        pc_hold       = frz | lu;
        if_id_hold    = frz | lu;
        if_id_flush   = fl | rd;
        id_ex_hold    = frz;
        id_ex_bubble  = rd | lu;
        ex_mem_hold   = frz;
        mem_wb_bubble = frz;
        if (rst) begin
            pc_hold       = 1'b0;
            if_id_hold    = 1'b0;
            if_id_flush   = 1'b1;
            id_ex_hold    = 1'b0;
            id_ex_bubble  = 1'b1;
            ex_mem_hold   = 1'b0;
            mem_wb_bubble = 1'b1;
        end
    end

    // Saturating perf counters
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (pc_hold && (stall_q != {STALL_CNT_W{1'b1}})) begin
            stall_d = stall_q + 1'b1;
        end
        if (rd && (flush_q != 16'hFFFF)) begin
            flush_d = flush_q + 16'd1;
        end
    end

    // State, counters and sticky flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_RUN;
            wait_q   <= '0;
            stall_q  <= '0;
            flush_q  <= '0;
            halted_q <= 1'b0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            stall_q  <= stall_d;
            flush_q  <= flush_d;
            halted_q <= halted_d;
            tmo_q    <= tmo_d;
        end
    end

    assign halted      = halted_q;
    assign timeout_err = tmo_q;
    assign stall_cnt   = stall_q;
    assign flush_cnt   = flush_q;

endmodule
